// File: rtl/pack_fifo.sv
// rtl/pack_fifo.sv - serializes one word into a byte FIFO, most-significant byte first
module pack_fifo #(
    parameter int WORD_BYTES = 16,
    parameter int CNT_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [WORD_BYTES*8-1:0] data_in,
    input  logic                    fifo_full,
    output logic                    ready,
    output logic                    push,
    output logic [7:0]              data_out,
    output logic                    done
);
    localparam int WORD_W = WORD_BYTES * 8;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              done_r;

    // Gated by rst so nothing is accepted or written during the reset cycle itself.
    assign ready    = (state == IDLE) && !rst;
    assign push     = (state == SEND) && !fifo_full && !rst;
    assign data_out = shreg[WORD_W-1 -: 8];
    assign done     = done_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg <= data_in;
                        cnt   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    // A stalled cycle leaves shreg and cnt untouched so data_out stays stable.
                    if (!fifo_full) begin
                        shreg <= shreg << 8;
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST_IDX) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pack_fifo.sv
// tb/tb_pack_fifo.sv - randomized and directed checks of pack_fifo against a byte-queue model
module tb_pack_fifo;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic [127:0] data_in = '0;
    logic         fifo_full = 1'b0;
    logic         ready;
    logic         push;
    logic [7:0]   data_out;
    logic         done;

    pack_fifo #(.WORD_BYTES(16), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .fifo_full(fifo_full),
        .ready(ready), .push(push), .data_out(data_out), .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit started = 0;

    // Model: bytes still owed for the word in flight, plus a pending done pulse.
    logic [7:0] q[$];
    bit         done_exp = 0;

    // Observed activity, for the directed literal checks.
    logic [7:0] push_bytes[$];
    int         push_cyc[$];
    int         done_cyc[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            logic       e_ready, e_push;
            logic [7:0] e_data;
            cyc++;
            e_ready = (q.size() == 0) && !done_exp && !rst;
            e_push  = (q.size() != 0) && !fifo_full && !rst;
            e_data  = (q.size() != 0) ? q[0] : 8'h00;
            check("ready", 128'(ready), 128'(e_ready));
            check("push", 128'(push), 128'(e_push));
            check("data_out", 128'(data_out), 128'(e_data));
            check("done", 128'(done), 128'(done_exp));
            if (push === 1'b1) begin
                push_bytes.push_back(data_out);
                push_cyc.push_back(cyc);
            end
            if (done === 1'b1) done_cyc.push_back(cyc);
            if (rst) begin
                q.delete();
                done_exp = 0;
            end else if (done_exp) begin
                done_exp = 0;
            end else if (q.size() == 0) begin
                if (load)
                    for (int i = 0; i < 16; i++) q.push_back(data_in[127-8*i -: 8]);
            end else if (!fifo_full) begin
                void'(q.pop_front());
                if (q.size() == 0) done_exp = 1;
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        push_bytes.delete();
        push_cyc.delete();
        done_cyc.delete();
    endtask

    function automatic logic [127:0] make_word(input logic [7:0] first, input logic [7:0] step);
        logic [127:0] w;
        for (int i = 0; i < 16; i++) w[127-8*i -: 8] = first + 8'(i) * step;
        return w;
    endfunction

    task automatic load_word(input logic [127:0] w);
        load = 1'b1;
        data_in = w;
        tick();
        load = 1'b0;
        data_in = '0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({name, "_ready_timeout"}, 128'(ready), 128'(1'b1));
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        started = 1;
        tick();
        rst = 1'b0;
        #3;
        check("reset_ready", 128'(ready), 128'(1'b1));
        check("reset_data", 128'(data_out), 128'h00);
        check("reset_done", 128'(done), 128'(1'b0));
        tick(2);

        // Basic word
        clear_logs();
        load_word(128'h00112233445566778899AABBCCDDEEFF);
        tick(18);
        check("basic_npush", 128'(push_bytes.size()), 128'd16);
        for (int i = 0; i < push_bytes.size() && i < 16; i++) begin
            check("basic_byte", 128'(push_bytes[i]), 128'(8'(i * 8'h11)));
            check("basic_consec", 128'(push_cyc[i] - push_cyc[0]), 128'(i));
        end
        check("basic_ndone", 128'(done_cyc.size()), 128'd1);
        if (done_cyc.size() == 1 && push_cyc.size() == 16)
            check("basic_done_cyc", 128'(done_cyc[0] - push_cyc[15]), 128'd1);

        // Backpressure: 3-cycle stall on 0x44, 2-cycle stall on 0xFF
        clear_logs();
        load_word(128'h00112233445566778899AABBCCDDEEFF);
        tick(4);
        fifo_full = 1'b1;
        #3;
        check("bp_hold_44", 128'(data_out), 128'h44);
        tick(3);
        fifo_full = 1'b0;
        tick(11);
        fifo_full = 1'b1;
        #3;
        check("bp_hold_ff", 128'(data_out), 128'hFF);
        tick(2);
        fifo_full = 1'b0;
        tick(3);
        check("bp_npush", 128'(push_bytes.size()), 128'd16);
        if (push_bytes.size() == 16) begin
            check("bp_byte4", 128'(push_bytes[4]), 128'h44);
            check("bp_last", 128'(push_bytes[15]), 128'hFF);
            check("bp_gap", 128'(push_cyc[4] - push_cyc[3]), 128'd4);
        end
        check("bp_ndone", 128'(done_cyc.size()), 128'd1);
        if (done_cyc.size() == 1 && push_cyc.size() == 16)
            check("bp_done_cyc", 128'(done_cyc[0] - push_cyc[15]), 128'd1);

        // Ignored load mid-word
        clear_logs();
        load_word({16{8'hA5}});
        tick(2);
        load_word({16{8'h5A}});
        tick(16);
        check("ign_npush", 128'(push_bytes.size()), 128'd16);
        foreach (push_bytes[i]) check("ign_byte", 128'(push_bytes[i]), 128'hA5);
        check("ign_ndone", 128'(done_cyc.size()), 128'd1);

        // Mid-word reset after the 7th push
        clear_logs();
        load_word(make_word(8'h01, 8'h01));
        tick(7);
        rst = 1'b1;
        #3;
        check("rst_push", 128'(push), 128'(1'b0));
        check("rst_ready", 128'(ready), 128'(1'b0));
        tick();
        rst = 1'b0;
        #3;
        check("rst_after_ready", 128'(ready), 128'(1'b1));
        check("rst_after_data", 128'(data_out), 128'h00);
        tick(3);
        check("rst_npush", 128'(push_bytes.size()), 128'd7);
        check("rst_ndone", 128'(done_cyc.size()), 128'd0);
        clear_logs();
        load_word(make_word(8'hFF, 8'hEF));
        tick(18);
        check("rst_new_npush", 128'(push_bytes.size()), 128'd16);
        if (push_bytes.size() == 16) begin
            check("rst_new_first", 128'(push_bytes[0]), 128'hFF);
            check("rst_new_last", 128'(push_bytes[15]), 128'h00);
        end

        // Back-to-back
        clear_logs();
        load_word(128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0);
        tick();
        wait_ready("b2b");
        load_word(128'hF0E1D2C3B4A5968778695A4B3C2D1E0F);
        tick(18);
        check("b2b_npush", 128'(push_bytes.size()), 128'd32);
        if (push_bytes.size() == 32) begin
            check("b2b_spacing", 128'(push_cyc[16] - push_cyc[0]), 128'd18);
            check("b2b_w2_first", 128'(push_bytes[16]), 128'hF0);
        end
        check("b2b_ndone", 128'(done_cyc.size()), 128'd2);

        // Reset/load collision
        clear_logs();
        rst = 1'b1;
        load = 1'b1;
        data_in = {16{8'h33}};
        tick();
        rst = 1'b0;
        load = 1'b0;
        tick(4);
        check("coll_npush", 128'(push_bytes.size()), 128'd0);
        check("coll_ready", 128'(ready), 128'(1'b1));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            load      = ($urandom_range(7) == 0);
            data_in   = {$urandom, $urandom, $urandom, $urandom};
            fifo_full = ($urandom_range(2) == 0);
            rst       = ($urandom_range(199) == 0);
            tick();
        end
        load = 1'b0;
        fifo_full = 1'b0;
        rst = 1'b0;
        tick(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
